// File: rtl/scl_pkg.sv
// Shared types and helpers for the horizontal scaler line feeder.
package scl_pkg;

  typedef enum logic [1:0] {StIdle, StLoad, StGap, StPlay} scl_state_e;

  localparam int unsigned SclFracW = 10;

  // Top two fraction bits of the DDA accumulator select the filter phase.
  function automatic logic [1:0] scl_phase(input logic [31:0] acc, input int unsigned frac_w);
    return 2'((acc >> (frac_w - 2)) & 32'd3);
  endfunction

endpackage

// File: rtl/scl_line_ram.sv
// Simple dual-port line buffer: synchronous write, registered read (1-cycle latency).
module scl_line_ram #(
  parameter int unsigned MAX_W = 2048,
  parameter int unsigned AW    = 11
) (
  input  logic          clk_scl,
  input  logic          rst_n_scl,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [MAX_W];

  always_ff @(posedge clk_scl) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk_scl or negedge rst_n_scl) begin
    if (!rst_n_scl) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/scl_line_feeder.sv
// Captures one line, then replays it through a DDA at the output pixel rate.
// Optional SCL_FDR_MIRROR_EN replays the line right-to-left.
module scl_line_feeder
  import scl_pkg::*;
#(
  parameter int unsigned MAX_W   = 2048,
  parameter int unsigned FRAC_W  = SclFracW,
  parameter int unsigned STEP_W  = 13,
  parameter int unsigned GAP_CYC = 4
) (
  input  logic              clk_scl,
  input  logic              rst_n_scl,
  input  logic [7:0]        fdr_i_data,
  input  logic              fdr_i_valid,
  input  logic              fdr_i_last,
  output logic              fdr_o_ready,
  input  logic [STEP_W-1:0] cfg_step,
  input  logic [11:0]       cfg_out_width,
  output logic [7:0]        fdr_o_data,
  output logic              fdr_o_data_en,
  output logic [1:0]        fdr_o_flt,
  output logic              fdr_o_busy,
  output logic              fdr_o_ovf
);

  localparam int unsigned AW    = (MAX_W > 1) ? $clog2(MAX_W) : 1;
  localparam int unsigned WW    = AW + 1;
  localparam int unsigned ACC_W = 12 + 3 + FRAC_W;
  localparam int unsigned INT_W = ACC_W - FRAC_W;
  localparam int unsigned GW    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  scl_state_e        state_q, state_d;
  logic [AW-1:0]     wr_cnt_q;
  logic [WW-1:0]     w_in_q;
  logic [GW-1:0]     gap_cnt_q;
  logic [ACC_W-1:0]  acc_q;
  logic [11:0]       out_cnt_q;
  logic [STEP_W-1:0] step_q;
  logic [11:0]       owidth_q;
  logic              ovf_q, en_q;
  logic [1:0]        flt_q;

  logic load_beat, load_done, gap_done, play_done, play_act;
  logic [INT_W-1:0] src_int, last_idx, src_sel;
  logic [AW-1:0]    rd_addr;

  assign load_beat = (state_q == StLoad) && fdr_i_valid;
  assign load_done = load_beat && (fdr_i_last || (wr_cnt_q == AW'(MAX_W - 1)));
  assign gap_done  = (state_q == StGap) && (gap_cnt_q == GW'(GAP_CYC - 1));
  assign play_done = (state_q == StPlay) && (out_cnt_q == owidth_q - 12'd1);

  always_ff @(posedge clk_scl or negedge rst_n_scl) begin
    if (!rst_n_scl) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: state_d = StLoad;
      StLoad: if (load_done) state_d = StGap;
      StGap:  if (gap_done) state_d = (owidth_q == '0) ? StIdle : StPlay;
      StPlay: if (play_done) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    fdr_o_ready = (state_q == StLoad);
    fdr_o_busy  = (state_q != StIdle);
    play_act    = (state_q == StPlay);
  end

  // Source index clamped to the last loaded pixel (right-edge replication).
  always_comb begin
    src_int  = acc_q[ACC_W-1:FRAC_W];
    last_idx = INT_W'(w_in_q - WW'(1));
    src_sel  = (src_int > last_idx) ? last_idx : src_int;
`ifdef SCL_FDR_MIRROR_EN
    rd_addr  = AW'(last_idx - src_sel);
`else
    rd_addr  = AW'(src_sel);
`endif
  end

  always_ff @(posedge clk_scl or negedge rst_n_scl) begin
    if (!rst_n_scl) begin
      wr_cnt_q  <= '0;
      w_in_q    <= '0;
      gap_cnt_q <= '0;
      acc_q     <= '0;
      out_cnt_q <= '0;
      step_q    <= '0;
      owidth_q  <= '0;
      ovf_q     <= 1'b0;
      en_q      <= 1'b0;
      flt_q     <= '0;
    end else begin
      en_q  <= play_act;
      flt_q <= play_act ? scl_phase(32'(acc_q), FRAC_W) : 2'd0;
      // Line configuration is frozen on entry to LOAD.
      if (state_q == StIdle) begin
        step_q   <= cfg_step;
        owidth_q <= cfg_out_width;
        wr_cnt_q <= '0;
      end
      if (load_beat) begin
        if (load_done) begin
          w_in_q <= WW'(wr_cnt_q) + WW'(1);
          if (!fdr_i_last) begin
            ovf_q <= 1'b1;
          end
        end else begin
          wr_cnt_q <= wr_cnt_q + AW'(1);
        end
      end
      gap_cnt_q <= (state_q == StGap) ? gap_cnt_q + GW'(1) : '0;
      if (play_act) begin
        acc_q     <= acc_q + ACC_W'(step_q);
        out_cnt_q <= out_cnt_q + 12'd1;
      end else begin
        acc_q     <= '0;
        out_cnt_q <= '0;
      end
    end
  end

  scl_line_ram #(
    .MAX_W (MAX_W),
    .AW    (AW)
  ) u_line_ram (
    .clk_scl   (clk_scl),
    .rst_n_scl (rst_n_scl),
    .wr_en     (load_beat),
    .wr_addr   (wr_cnt_q),
    .wr_data   (fdr_i_data),
    .rd_en     (play_act),
    .rd_addr   (rd_addr),
    .rd_data   (fdr_o_data)
  );

  assign fdr_o_data_en = en_q;
  assign fdr_o_flt     = flt_q;
  assign fdr_o_ovf     = ovf_q;

endmodule

// File: tb/tb_scl_line_feeder.sv
// Directed bench for scl_line_feeder (small MAX_W so the overflow path is reachable).
module tb_scl_line_feeder;

  localparam int unsigned MaxW   = 8;
  localparam int unsigned GapCyc = 4;

  logic        clk_scl = 1'b0;
  logic        rst_n_scl = 1'b0;
  logic [7:0]  fdr_i_data = '0;
  logic        fdr_i_valid = 1'b0;
  logic        fdr_i_last = 1'b0;
  logic        fdr_o_ready;
  logic [12:0] cfg_step = '0;
  logic [11:0] cfg_out_width = '0;
  logic [7:0]  fdr_o_data;
  logic        fdr_o_data_en;
  logic [1:0]  fdr_o_flt;
  logic        fdr_o_busy;
  logic        fdr_o_ovf;

  scl_line_feeder #(
    .MAX_W   (MaxW),
    .FRAC_W  (10),
    .STEP_W  (13),
    .GAP_CYC (GapCyc)
  ) dut (
    .clk_scl       (clk_scl),
    .rst_n_scl     (rst_n_scl),
    .fdr_i_data    (fdr_i_data),
    .fdr_i_valid   (fdr_i_valid),
    .fdr_i_last    (fdr_i_last),
    .fdr_o_ready   (fdr_o_ready),
    .cfg_step      (cfg_step),
    .cfg_out_width (cfg_out_width),
    .fdr_o_data    (fdr_o_data),
    .fdr_o_data_en (fdr_o_data_en),
    .fdr_o_flt     (fdr_o_flt),
    .fdr_o_busy    (fdr_o_busy),
    .fdr_o_ovf     (fdr_o_ovf)
  );

  always #5 clk_scl = ~clk_scl;

  int n_cmp = 0;
  int n_fail = 0;
  int line_pix[$];
  int exp_idx[$];
  int exp_flt[$];

  task automatic tick();
    @(posedge clk_scl);
    #1;
  endtask

  task automatic check(input string tag, input string what, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s/%s: observed %0d expected %0d", tag, what, obs, exp);
    end
  endtask

  // Pixel the filter should see for source index idx of a w-pixel line.
  function automatic int exp_pix(input int idx, input int w);
`ifdef SCL_FDR_MIRROR_EN
    return line_pix[w - 1 - idx];
`else
    return line_pix[idx];
`endif
  endfunction

  task automatic load_line(input bit use_last, output int accepted);
    accepted = 0;
    for (int i = 0; i < line_pix.size(); i++) begin
      if (fdr_o_ready !== 1'b1) break;
      fdr_i_valid = 1'b1;
      fdr_i_data  = 8'(line_pix[i]);
      fdr_i_last  = use_last && (i == line_pix.size() - 1);
      tick();
      accepted++;
    end
    fdr_i_valid = 1'b0;
    fdr_i_last  = 1'b0;
  endtask

  task automatic run_line(input string tag, input int step, input int width, input bit use_last,
                          input int exp_w);
    int acc_n;
    int low_n;
    bit seen;
    cfg_step      = 13'(step);
    cfg_out_width = 12'(width);
    rst_n_scl = 1'b0;
    tick();
    rst_n_scl = 1'b1;
    tick();
    check(tag, "ready_in_load", fdr_o_ready, 1);
    // Latched configuration must survive these changes.
    cfg_step      = '1;
    cfg_out_width = 12'd4095;
    load_line(use_last, acc_n);
    check(tag, "accepted", acc_n, exp_w);
    check(tag, "ready_after_load", fdr_o_ready, 0);
    check(tag, "ovf", fdr_o_ovf, use_last ? 0 : 1);
    low_n = 0;
    seen = 1'b0;
    if (width == 0) begin
      while (fdr_o_busy === 1'b1 && low_n < 40) begin
        if (fdr_o_data_en === 1'b1) seen = 1'b1;
        tick();
        low_n++;
      end
      check(tag, "gap_to_idle", low_n, GapCyc);
      check(tag, "en_seen", seen, 0);
    end else begin
      // GAP cycles plus the first PLAY cycle before registered en rises.
      while (fdr_o_data_en !== 1'b1 && low_n < 40) begin
        tick();
        low_n++;
      end
      check(tag, "en_low_cycles", low_n, GapCyc + 1);
      for (int k = 0; k < width; k++) begin
        check(tag, $sformatf("en[%0d]", k), fdr_o_data_en, 1);
        check(tag, $sformatf("data[%0d]", k), fdr_o_data, exp_pix(exp_idx[k], exp_w));
        check(tag, $sformatf("flt[%0d]", k), fdr_o_flt, exp_flt[k]);
        tick();
      end
      check(tag, "en_fall", fdr_o_data_en, 0);
    end
  endtask

  initial begin
    int acc_n;
    int wait_n;
    tick();
    check("reset", "ready", fdr_o_ready, 0);
    check("reset", "busy", fdr_o_busy, 0);
    check("reset", "en", fdr_o_data_en, 0);
    check("reset", "data", fdr_o_data, 0);
    check("reset", "flt", fdr_o_flt, 0);
    check("reset", "ovf", fdr_o_ovf, 0);

    line_pix = '{10, 20, 30, 40};
    exp_idx = '{0, 1, 2, 3};             exp_flt = '{0, 0, 0, 0};
    run_line("unity", 1024, 4, 1'b1, 4);
    exp_idx = '{0, 0, 1, 1, 2, 2, 3, 3}; exp_flt = '{0, 2, 0, 2, 0, 2, 0, 2};
    run_line("half", 512, 8, 1'b1, 4);
    exp_idx = '{0, 2};                   exp_flt = '{0, 0};
    run_line("double", 2048, 2, 1'b1, 4);
    exp_idx = '{0, 0, 0, 0};             exp_flt = '{0, 1, 2, 3};
    run_line("quarter", 256, 4, 1'b1, 4);
    exp_idx = '{0, 1, 2, 3, 3, 3};       exp_flt = '{0, 0, 0, 0, 0, 0};
    run_line("clamp", 1024, 6, 1'b1, 4);
    exp_idx = '{0, 1, 3, 3};             exp_flt = '{0, 2, 0, 2};
    run_line("one_half", 1536, 4, 1'b1, 4);
    exp_idx = '{0, 0, 0};                exp_flt = '{0, 0, 0};
    run_line("step0", 0, 3, 1'b1, 4);
    run_line("width0", 1024, 0, 1'b1, 4);

    line_pix = '{5, 8, 11, 14, 17, 20, 23, 26, 29, 32};
    exp_idx = '{0, 1, 2, 3, 4, 5, 6, 7, 7, 7};
    exp_flt = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    run_line("overflow", 1024, 10, 1'b0, 8);

    // Next line was latched with the junk config; ovf must still be set.
    check("abort", "ovf_sticky", fdr_o_ovf, 1);
    check("abort", "ready", fdr_o_ready, 1);
    line_pix = '{10, 20, 30, 40};
    load_line(1'b1, acc_n);
    check("abort", "accepted", acc_n, 4);
    wait_n = 0;
    while (fdr_o_data_en !== 1'b1 && wait_n < 40) begin
      tick();
      wait_n++;
    end
    check("abort", "en_high", fdr_o_data_en, 1);
    check("abort", "first_data", fdr_o_data, exp_pix(0, 4));
    rst_n_scl = 1'b0;
    #1;
    check("abort", "en", fdr_o_data_en, 0);
    check("abort", "data", fdr_o_data, 0);
    check("abort", "flt", fdr_o_flt, 0);
    check("abort", "busy", fdr_o_busy, 0);
    check("abort", "ovf", fdr_o_ovf, 0);
    check("abort", "ready", fdr_o_ready, 0);
    tick();
    rst_n_scl = 1'b1;
    #1;
    check("abort", "idle_busy", fdr_o_busy, 0);
    tick();
    check("abort", "load_ready", fdr_o_ready, 1);
    check("abort", "load_ovf", fdr_o_ovf, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
